// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and the branch unit:
// condition-code layout, reset value and the NZP derivation.
package regfile_pkg;

    localparam logic [2:0] CC_RESET = 3'b010;

    localparam int CC_N = 2;
    localparam int CC_Z = 1;
    localparam int CC_P = 0;

    // Widest data word cc_of() accepts; callers zero-extend into this.
    localparam int CC_MAX_W = 64;

    // NZP of a two's-complement value 'width' bits wide, held zero-extended in data.
    function automatic logic [2:0] cc_of(input logic [CC_MAX_W-1:0] data,
                                         input int unsigned width);
        logic [CC_MAX_W-1:0] sign_shifted;
        logic [2:0] cc;
        sign_shifted = data >> (width - 1);
        cc = '0;
        cc[CC_N] = sign_shifted[0];
        cc[CC_Z] = (data == '0);
        cc[CC_P] = !cc[CC_N] && !cc[CC_Z];
        return cc;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Issue/write-back/read bundle of the scoreboarded register file.
// master = pipeline side driving requests, slave = the register file.
interface regfile_sb_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2
);
    localparam int ADDR_W = $clog2(NUM_REGS);

    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     ldcc;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic [2:0]               nzp;

    modport master (
        output wr_en, wr_addr, wr_data, ldcc, issue_en, issue_addr, rd_addr,
        input  rd_data, rd_busy, nzp
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, ldcc, issue_en, issue_addr, rd_addr,
        output rd_data, rd_busy, nzp
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, write-back clears, issue wins on a tie.
// Reports the busy bit of each read port's register, optionally bypassed.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                     clk_50,
    input  logic                     reset,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_busy
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;

    // NOTE: every variable assigned in always_comb gets a default first so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        busy_next = busy;
        if (wr_en)    busy_next[wr_addr]    = 1'b0;
        if (issue_en) busy_next[issue_addr] = 1'b1;
    end

    always_ff @(posedge clk_50) begin
        if (reset) busy <= '0;
        else       busy <= busy_next;
    end

    // With bypass, a port reading the write-back target sees the post-edge bit,
    // which is 1 only when a new producer issues to that register this cycle.
    always_comb begin
        rd_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (BYPASS != 0 && wr_en && rd_addr[k*ADDR_W +: ADDR_W] == wr_addr)
                rd_busy[k] = busy_next[wr_addr];
            else
                rd_busy[k] = busy[rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with write-to-read bypass, busy scoreboard and
// NZP condition-code register. DATA_W must not exceed regfile_pkg::CC_MAX_W.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1
) (
    input  logic         clk_50,
    input  logic         reset,
    regfile_sb_if.slave  bus
);

    localparam int ADDR_W = $clog2(NUM_REGS);

    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [2:0]               nzp_q;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    // NOTE: the register array is cleared on reset, which maps it onto flops
    // rather than a RAM macro; acceptable at register-file sizes.
    always_ff @(posedge clk_50) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            nzp_q <= CC_RESET;
        end else begin
            if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
            if (bus.ldcc)  nzp_q <= cc_of(CC_MAX_W'(bus.wr_data), DATA_W);
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (BYPASS != 0 && bus.wr_en && bus.rd_addr[k*ADDR_W +: ADDR_W] == bus.wr_addr)
                rd_data[k*DATA_W +: DATA_W] = bus.wr_data;
            else
                rd_data[k*DATA_W +: DATA_W] = regs[bus.rd_addr[k*ADDR_W +: ADDR_W]];
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .BYPASS   (BYPASS)
    ) u_scoreboard (
        .clk_50     (clk_50),
        .reset      (reset),
        .issue_en   (bus.issue_en),
        .issue_addr (bus.issue_addr),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .rd_addr    (bus.rd_addr),
        .rd_busy    (rd_busy)
    );

    assign bus.rd_data = rd_data;
    assign bus.rd_busy = rd_busy;
    assign bus.nzp     = nzp_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Drives a BYPASS=1 and a BYPASS=0 instance with identical stimulus and checks
// both against an array-based model of registers, busy flags and NZP.
module tb_regfile_sb;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int NUM_RD   = 2;
    localparam int ADDR_W   = 3;

    logic clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    logic                     reset;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     ldcc;
    logic                     issue_en;
    logic [ADDR_W-1:0]        issue_addr;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;

    regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus_byp ();
    regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD)) bus_raw ();

    assign bus_byp.wr_en      = wr_en;
    assign bus_byp.wr_addr    = wr_addr;
    assign bus_byp.wr_data    = wr_data;
    assign bus_byp.ldcc       = ldcc;
    assign bus_byp.issue_en   = issue_en;
    assign bus_byp.issue_addr = issue_addr;
    assign bus_byp.rd_addr    = rd_addr;
    assign bus_raw.wr_en      = wr_en;
    assign bus_raw.wr_addr    = wr_addr;
    assign bus_raw.wr_data    = wr_data;
    assign bus_raw.ldcc       = ldcc;
    assign bus_raw.issue_en   = issue_en;
    assign bus_raw.issue_addr = issue_addr;
    assign bus_raw.rd_addr    = rd_addr;

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .BYPASS(1)) dut_byp (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus_byp.slave)
    );

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .BYPASS(0)) dut_raw (
        .clk_50 (clk_50),
        .reset  (reset),
        .bus    (bus_raw.slave)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DATA_W-1:0] ref_regs [NUM_REGS];
    logic              ref_busy [NUM_REGS];
    logic [2:0]        ref_nzp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] port_addr(input int k);
        return rd_addr[k*ADDR_W +: ADDR_W];
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input bit byp, input int k);
        if (byp && wr_en && port_addr(k) == wr_addr) return wr_data;
        return ref_regs[port_addr(k)];
    endfunction

    // Bypassed busy shows what the register will be after the edge.
    function automatic logic ref_rd_busy(input bit byp, input int k);
        if (byp && wr_en && port_addr(k) == wr_addr) return issue_en && issue_addr == wr_addr;
        return ref_busy[port_addr(k)];
    endfunction

    function automatic logic [2:0] ref_cc(input logic [DATA_W-1:0] d);
        if ($signed(d) < 0) return 3'b100;
        if (d == 0)         return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_edge();
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ref_regs[i] = '0;
                ref_busy[i] = 1'b0;
            end
            ref_nzp = 3'b010;
        end else begin
            if (wr_en)    ref_regs[wr_addr] = wr_data;
            if (wr_en)    ref_busy[wr_addr] = 1'b0;
            if (issue_en) ref_busy[issue_addr] = 1'b1;
            if (ldcc)     ref_nzp = ref_cc(wr_data);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < NUM_RD; k++) begin
            check($sformatf("byp rd_data[%0d]", k), 32'(bus_byp.rd_data[k*DATA_W +: DATA_W]), 32'(ref_rd(1'b1, k)));
            check($sformatf("raw rd_data[%0d]", k), 32'(bus_raw.rd_data[k*DATA_W +: DATA_W]), 32'(ref_rd(1'b0, k)));
            check($sformatf("byp rd_busy[%0d]", k), 32'(bus_byp.rd_busy[k]), 32'(ref_rd_busy(1'b1, k)));
            check($sformatf("raw rd_busy[%0d]", k), 32'(bus_raw.rd_busy[k]), 32'(ref_rd_busy(1'b0, k)));
        end
        check("byp nzp", 32'(bus_byp.nzp), 32'(ref_nzp));
        check("raw nzp", 32'(bus_raw.nzp), 32'(ref_nzp));
    endtask

    // Inputs are applied at posedge+1; outputs compared at posedge+2.
    task automatic step();
        #1;
        compare_all();
        @(posedge clk_50);
        #1;
        model_edge();
    endtask

    task automatic idle();
        reset    = 1'b0;
        wr_en    = 1'b0;
        ldcc     = 1'b0;
        issue_en = 1'b0;
    endtask

    task automatic check_all_clear(input string tag);
        for (int a = 0; a < NUM_REGS; a++) begin
            rd_addr = {3'(NUM_REGS - 1 - a), 3'(a)};
            #1;
            for (int k = 0; k < NUM_RD; k++) begin
                check({tag, " byp data"}, 32'(bus_byp.rd_data[k*DATA_W +: DATA_W]), 32'd0);
                check({tag, " raw data"}, 32'(bus_raw.rd_data[k*DATA_W +: DATA_W]), 32'd0);
                check({tag, " byp busy"}, 32'(bus_byp.rd_busy[k]), 32'd0);
            end
        end
        check({tag, " byp nzp"}, 32'(bus_byp.nzp), 32'h2);
        check({tag, " raw nzp"}, 32'(bus_raw.nzp), 32'h2);
    endtask

    initial begin
        idle();
        reset      = 1'b1;
        wr_addr    = '0;
        wr_data    = '0;
        issue_addr = '0;
        rd_addr    = '0;
        @(posedge clk_50);
        #1;
        model_edge();
        idle();

        check_all_clear("reset");
        for (int a = 0; a < NUM_REGS; a++) begin
            rd_addr = {3'(NUM_REGS - 1 - a), 3'(a)};
            step();
        end

        // Same-cycle write and read of reg 3.
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'd17; rd_addr = {3'd0, 3'd3};
        #1;
        check("bypass wr3 before edge", 32'(bus_byp.rd_data[15:0]), 32'd17);
        check("raw wr3 before edge", 32'(bus_raw.rd_data[15:0]), 32'd0);
        step();
        idle();
        #1;
        check("raw wr3 after edge", 32'(bus_raw.rd_data[15:0]), 32'd17);

        // Issue reg 5, observe busy, then write it back.
        issue_en = 1'b1; issue_addr = 3'd5;
        step();
        idle();
        rd_addr = {3'd5, 3'd0};
        #1;
        check("busy5 byp", 32'(bus_byp.rd_busy[1]), 32'd1);
        check("busy5 raw", 32'(bus_raw.rd_busy[1]), 32'd1);
        step();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h0020;
        step();
        idle();
        #1;
        check("busy5 cleared", 32'(bus_raw.rd_busy[1]), 32'd0);
        check("reg5 data", 32'(bus_raw.rd_data[31:16]), 32'h0020);

        // Issue and write-back to reg 2 in the same cycle: set wins.
        issue_en = 1'b1; issue_addr = 3'd2; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
        rd_addr = {3'd2, 3'd2};
        step();
        idle();
        #1;
        check("busy2 set wins byp", 32'(bus_byp.rd_busy[0]), 32'd1);
        check("busy2 set wins raw", 32'(bus_raw.rd_busy[1]), 32'd1);

        // Condition codes from negative, zero, positive.
        ldcc = 1'b1; wr_data = 16'hFFFF;
        step();
        check("nzp neg", 32'(bus_byp.nzp), 32'h4);
        wr_data = 16'h0000;
        step();
        check("nzp zero", 32'(bus_byp.nzp), 32'h2);
        wr_data = 16'h0001;
        step();
        check("nzp pos", 32'(bus_raw.nzp), 32'h1);
        idle();

        // Fill regs 1..4, issue 6, then reset with conflicting requests.
        for (int r = 1; r <= 4; r++) begin
            wr_en = 1'b1; wr_addr = 3'(r); wr_data = 16'(16'hA000 + r);
            step();
        end
        idle();
        issue_en = 1'b1; issue_addr = 3'd6; ldcc = 1'b1; wr_data = 16'h8000;
        step();
        idle();
        reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 16'hBEEF;
        issue_en = 1'b1; issue_addr = 3'd7; ldcc = 1'b1;
        step();
        idle();
        check_all_clear("mid reset");

        // Randomised traffic with corner-value data.
        for (int n = 0; n < 1500; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            wr_en      = 1'($urandom_range(0, 1));
            ldcc       = ($urandom_range(0, 3) == 0);
            issue_en   = 1'($urandom_range(0, 1));
            wr_addr    = 3'($urandom_range(0, NUM_REGS - 1));
            issue_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 3'($urandom_range(0, NUM_REGS - 1));
            case ($urandom_range(0, 5))
                0:       wr_data = 16'h0000;
                1:       wr_data = 16'hFFFF;
                2:       wr_data = 16'h8000;
                3:       wr_data = 16'h7FFF;
                default: wr_data = 16'($urandom);
            endcase
            for (int k = 0; k < NUM_RD; k++)
                rd_addr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 2) == 0) ? wr_addr
                                             : 3'($urandom_range(0, NUM_REGS - 1));
            step();
        end
        idle();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
